nrisc_firq_ctrl: RTL and testbench

Fast-interrupt (FIRQ) controller for the NRISC core. It arbitrates external interrupt requests and waits for an instruction boundary before redirecting the PC to a per-source vector. It saves the return PC and drives the bank-select flag that switches the register file's R8–R15 between the user and FIRQ banks. It sits directly upstream of the register file's `REG_Interrupt_flag` input and beside the fetch stage's PC mux.

---
 rtl/nrisc_firq_ctrl.sv | 112 +++++++++++
 tb/tb_nrisc_firq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_firq_ctrl.sv
// nrisc_firq_ctrl: fast-interrupt controller; arbitrates requests, redirects fetch at instruction boundaries, selects the FIRQ register bank
`ifndef TAM
`define TAM 16
`endif

module nrisc_firq_ctrl #(
    parameter int TAM = `TAM,
    parameter int NUM_SRC = 4,
    parameter logic [TAM-1:0] VECTOR_BASE = TAM'(16'h0010),
    parameter int VEC_STRIDE = 4,
    localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               irq_enable,
    input  logic               instr_boundary,
    input  logic [TAM-1:0]     pc_next,
    input  logic               firq_ret,
    output logic               pc_redirect,
    output logic [TAM-1:0]     pc_target,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [IDW-1:0]     irq_id,
    output logic [TAM-1:0]     saved_pc,
    output logic               REG_Interrupt_flag
);

    typedef enum logic [2:0] {IDLE, PENDING, ENTER, ACTIVE, LEAVE} state_t;

    state_t             state, state_n;
    logic [IDW-1:0]     arb_id, id_n;
    logic [TAM-1:0]     vec_target, target_n, saved_n;
    logic [NUM_SRC-1:0] ack_n;
    logic               redirect_n, flag_n, req_any;

    assign req_any = |irq_req;
    assign vec_target = VECTOR_BASE + TAM'(VEC_STRIDE) * TAM'(arb_id);

    // fixed-priority arbiter: lowest set request index wins
    always_comb begin
        arb_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (irq_req[i]) arb_id = IDW'(i);
    end

    // next state and next registered outputs; redirect/ack are single-cycle pulses
    always_comb begin
        state_n    = state;
        id_n       = irq_id;
        target_n   = pc_target;
        saved_n    = saved_pc;
        redirect_n = 1'b0;
        ack_n      = '0;
        flag_n     = REG_Interrupt_flag;
        case (state)
            IDLE: begin
                if (irq_enable && req_any) begin
                    id_n    = arb_id;
                    state_n = PENDING;
                end
            end
            PENDING: begin
                if (!irq_enable || !req_any) begin
                    state_n = IDLE;
                end else begin
                    id_n = arb_id;
                    if (instr_boundary) begin
                        saved_n    = pc_next;
                        target_n   = vec_target;
                        redirect_n = 1'b1;
                        ack_n      = NUM_SRC'(1) << arb_id;
                        flag_n     = 1'b1;
                        state_n    = ENTER;
                    end
                end
            end
            ENTER: state_n = ACTIVE;
            ACTIVE: begin
                if (instr_boundary && firq_ret) begin
                    target_n   = saved_pc;
                    redirect_n = 1'b1;
                    flag_n     = 1'b0;
                    state_n    = LEAVE;
                end
            end
            LEAVE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            irq_id             <= '0;
            pc_target          <= '0;
            saved_pc           <= '0;
            pc_redirect        <= 1'b0;
            irq_ack            <= '0;
            REG_Interrupt_flag <= 1'b0;
        end else begin
            state              <= state_n;
            irq_id             <= id_n;
            pc_target          <= target_n;
            saved_pc           <= saved_n;
            pc_redirect        <= redirect_n;
            irq_ack            <= ack_n;
            REG_Interrupt_flag <= flag_n;
        end
    end

endmodule

// File: tb/tb_nrisc_firq_ctrl.sv
// tb_nrisc_firq_ctrl: directed tests of the FIRQ controller
module tb_nrisc_firq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_req = '0;
    logic        irq_enable = 1'b0;
    logic        instr_boundary = 1'b0;
    logic [15:0] pc_next = '0;
    logic        firq_ret = 1'b0;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic [3:0]  irq_ack;
    logic [1:0]  irq_id;
    logic [15:0] saved_pc;
    logic        flag;

    logic [3:0]  w_req = '0;
    logic        w_en = 1'b0;
    logic        w_bnd = 1'b0;
    logic [7:0]  w_pc = '0;
    logic        w_ret = 1'b0;
    logic        w_redirect;
    logic [7:0]  w_target;
    logic [3:0]  w_ack;
    logic [1:0]  w_id;
    logic [7:0]  w_saved;
    logic        w_flag;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    nrisc_firq_ctrl #(.TAM(16), .NUM_SRC(4), .VECTOR_BASE(16'h0010), .VEC_STRIDE(4)) dut (
        .clk(clk), .rst(rst), .irq_req(irq_req), .irq_enable(irq_enable),
        .instr_boundary(instr_boundary), .pc_next(pc_next), .firq_ret(firq_ret),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .irq_ack(irq_ack),
        .irq_id(irq_id), .saved_pc(saved_pc), .REG_Interrupt_flag(flag)
    );

    nrisc_firq_ctrl #(.TAM(8), .NUM_SRC(4), .VECTOR_BASE(8'hF8), .VEC_STRIDE(4)) dut_w (
        .clk(clk), .rst(rst), .irq_req(w_req), .irq_enable(w_en),
        .instr_boundary(w_bnd), .pc_next(w_pc), .firq_ret(w_ret),
        .pc_redirect(w_redirect), .pc_target(w_target), .irq_ack(w_ack),
        .irq_id(w_id), .saved_pc(w_saved), .REG_Interrupt_flag(w_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (pc_redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got %b want 0", pc_redirect); end
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL reset_flag got %b want 0", flag); end
        total++; if (irq_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got %b want 0000", irq_ack); end
        total++; if (irq_id !== 2'd0) begin bad++; $display("FAIL reset_id got %0d want 0", irq_id); end
        total++; if (pc_target !== 16'h0000) begin bad++; $display("FAIL reset_target got %h want 0000", pc_target); end
        total++; if (saved_pc !== 16'h0000) begin bad++; $display("FAIL reset_saved got %h want 0000", saved_pc); end
        total++; if (w_target !== 8'h00 || w_saved !== 8'h00) begin bad++; $display("FAIL reset_w got %h/%h want 00/00", w_target, w_saved); end
    endtask

    task automatic test_single();
        irq_enable = 1'b1;
        irq_req = 4'b0100;
        tick();
        total++; if (irq_id !== 2'd2) begin bad++; $display("FAIL single_pending_id got %0d want 2", irq_id); end
        total++; if (pc_redirect !== 1'b0) begin bad++; $display("FAIL single_pending_redirect got %b want 0", pc_redirect); end
        instr_boundary = 1'b1;
        pc_next = 16'h0123;
        tick();
        instr_boundary = 1'b0;
        irq_req = 4'b0000;
        total++; if (pc_redirect !== 1'b1) begin bad++; $display("FAIL single_enter_redirect got %b want 1", pc_redirect); end
        total++; if (pc_target !== 16'h0018) begin bad++; $display("FAIL single_enter_target got %h want 0018", pc_target); end
        total++; if (irq_ack !== 4'b0100) begin bad++; $display("FAIL single_enter_ack got %b want 0100", irq_ack); end
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL single_enter_flag got %b want 1", flag); end
        total++; if (saved_pc !== 16'h0123) begin bad++; $display("FAIL single_enter_saved got %h want 0123", saved_pc); end
        tick();
        total++; if (pc_redirect !== 1'b0 || irq_ack !== 4'b0000) begin bad++; $display("FAIL single_active_pulse got %b/%b want 0/0000", pc_redirect, irq_ack); end
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL single_active_flag got %b want 1", flag); end
        instr_boundary = 1'b1;
        firq_ret = 1'b1;
        tick();
        instr_boundary = 1'b0;
        firq_ret = 1'b0;
        total++; if (pc_redirect !== 1'b1) begin bad++; $display("FAIL single_leave_redirect got %b want 1", pc_redirect); end
        total++; if (pc_target !== 16'h0123) begin bad++; $display("FAIL single_leave_target got %h want 0123", pc_target); end
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL single_leave_flag got %b want 0", flag); end
        tick();
        total++; if (pc_redirect !== 1'b0 || pc_target !== 16'h0123) begin bad++; $display("FAIL single_idle got %b/%h want 0/0123", pc_redirect, pc_target); end
    endtask

    task automatic test_priority();
        irq_req = 4'b1000;
        tick();
        total++; if (irq_id !== 2'd3) begin bad++; $display("FAIL prio_first_id got %0d want 3", irq_id); end
        irq_req = 4'b1010;
        tick();
        total++; if (irq_id !== 2'd1) begin bad++; $display("FAIL prio_rearb_id got %0d want 1", irq_id); end
        instr_boundary = 1'b1;
        pc_next = 16'h0200;
        tick();
        instr_boundary = 1'b0;
        irq_req = 4'b0000;
        total++; if (pc_target !== 16'h0014) begin bad++; $display("FAIL prio_target got %h want 0014", pc_target); end
        total++; if (irq_ack !== 4'b0010) begin bad++; $display("FAIL prio_ack got %b want 0010", irq_ack); end
        total++; if (saved_pc !== 16'h0200) begin bad++; $display("FAIL prio_saved got %h want 0200", saved_pc); end
        tick();
        instr_boundary = 1'b1;
        firq_ret = 1'b1;
        tick();
        instr_boundary = 1'b0;
        firq_ret = 1'b0;
        total++; if (pc_target !== 16'h0200 || flag !== 1'b0) begin bad++; $display("FAIL prio_leave got %h/%b want 0200/0", pc_target, flag); end
        tick();
    endtask

    task automatic test_withdraw();
        irq_req = 4'b0001;
        tick();
        irq_req = 4'b0000;
        instr_boundary = 1'b1;
        pc_next = 16'h0ABC;
        tick();
        instr_boundary = 1'b0;
        total++; if (pc_redirect !== 1'b0 || irq_ack !== 4'b0000) begin bad++; $display("FAIL withdraw_pulse got %b/%b want 0/0000", pc_redirect, irq_ack); end
        total++; if (saved_pc !== 16'h0200) begin bad++; $display("FAIL withdraw_saved got %h want 0200", saved_pc); end
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL withdraw_flag got %b want 0", flag); end
        irq_req = 4'b0001;
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        irq_req = 4'b0000;
        total++; if (pc_redirect !== 1'b0) begin bad++; $display("FAIL withdraw_idle_boundary got %b want 0", pc_redirect); end
        tick();
    endtask

    task automatic test_no_nest();
        irq_req = 4'b0100;
        tick();
        instr_boundary = 1'b1;
        pc_next = 16'h0300;
        tick();
        instr_boundary = 1'b0;
        irq_req = 4'b0001;
        total++; if (pc_redirect !== 1'b1 || irq_ack !== 4'b0100) begin bad++; $display("FAIL nest_enter got %b/%b want 1/0100", pc_redirect, irq_ack); end
        tick();
        instr_boundary = 1'b1;
        pc_next = 16'h0310;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (pc_redirect !== 1'b0 || irq_ack !== 4'b0000 || flag !== 1'b1) begin bad++; $display("FAIL nest_held got %b/%b/%b want 0/0000/1", pc_redirect, irq_ack, flag); end
        end
        total++; if (saved_pc !== 16'h0300) begin bad++; $display("FAIL nest_saved got %h want 0300", saved_pc); end
        firq_ret = 1'b1;
        tick();
        firq_ret = 1'b0;
        pc_next = 16'h0400;
        total++; if (pc_redirect !== 1'b1 || pc_target !== 16'h0300 || flag !== 1'b0) begin bad++; $display("FAIL nest_leave got %b/%h/%b want 1/0300/0", pc_redirect, pc_target, flag); end
        tick();
        total++; if (pc_redirect !== 1'b0 || flag !== 1'b0) begin bad++; $display("FAIL nest_gap1 got %b/%b want 0/0", pc_redirect, flag); end
        tick();
        total++; if (pc_redirect !== 1'b0 || flag !== 1'b0) begin bad++; $display("FAIL nest_gap2 got %b/%b want 0/0", pc_redirect, flag); end
        tick();
        instr_boundary = 1'b0;
        irq_req = 4'b0000;
        total++; if (pc_redirect !== 1'b1 || pc_target !== 16'h0010 || irq_ack !== 4'b0001) begin bad++; $display("FAIL nest_reenter got %b/%h/%b want 1/0010/0001", pc_redirect, pc_target, irq_ack); end
        total++; if (saved_pc !== 16'h0400 || flag !== 1'b1) begin bad++; $display("FAIL nest_reenter_saved got %h/%b want 0400/1", saved_pc, flag); end
        tick();
        instr_boundary = 1'b1;
        firq_ret = 1'b1;
        tick();
        tick();
        total++; if (pc_redirect !== 1'b0 || flag !== 1'b0 || pc_target !== 16'h0400) begin bad++; $display("FAIL idle_ret got %b/%b/%h want 0/0/0400", pc_redirect, flag, pc_target); end
        instr_boundary = 1'b0;
        firq_ret = 1'b0;
    endtask

    task automatic test_reset_active();
        irq_req = 4'b0100;
        tick();
        instr_boundary = 1'b1;
        pc_next = 16'h0500;
        tick();
        instr_boundary = 1'b0;
        irq_req = 4'b0000;
        tick();
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL rstact_pre_flag got %b want 1", flag); end
        rst = 1'b1;
        instr_boundary = 1'b1;
        firq_ret = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (flag !== 1'b0 || pc_redirect !== 1'b0) begin bad++; $display("FAIL rstact_out got %b/%b want 0/0", flag, pc_redirect); end
        total++; if (pc_target !== 16'h0000 || saved_pc !== 16'h0000) begin bad++; $display("FAIL rstact_regs got %h/%h want 0000/0000", pc_target, saved_pc); end
        tick();
        total++; if (pc_redirect !== 1'b0) begin bad++; $display("FAIL rstact_idle got %b want 0", pc_redirect); end
        instr_boundary = 1'b0;
        firq_ret = 1'b0;
    endtask

    task automatic test_wrap();
        w_en = 1'b1;
        w_req = 4'b1000;
        tick();
        w_bnd = 1'b1;
        w_pc = 8'h33;
        tick();
        w_bnd = 1'b0;
        total++; if (w_target !== 8'h04) begin bad++; $display("FAIL wrap_target got %h want 04", w_target); end
        total++; if (w_ack !== 4'b1000 || w_redirect !== 1'b1) begin bad++; $display("FAIL wrap_ack got %b/%b want 1000/1", w_ack, w_redirect); end
        total++; if (w_saved !== 8'h33) begin bad++; $display("FAIL wrap_saved got %h want 33", w_saved); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_withdraw();
        test_no_nest();
        test_reset_active();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
